// File: rtl/variance_detector.sv
// Computes VAR_SCALED = N*Tsum_square - Tsum^2 (clamped at 0) with a 16-step serial squarer, plus a threshold alarm.
// Optional build macro VARIANCE_HYST_EN adds hysteresis to ALARM (set above THRESH, clear at or below THRESH>>1).
module variance_detector #(
  parameter int WINDOW = 14
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [15:0] Tsum,
  input  logic [27:0] Tsum_square,
  input  logic [31:0] THRESH,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] VAR_SCALED,
  output logic        ALARM,
  output logic        OVERRUN,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_SUB  = 2'd2;
  localparam logic [31:0] N_SCALE = WINDOW;

  // Handshake: START is sampled only on an idle, non-DONE edge; any other START
  // is dropped and latches OVERRUN. DONE is a one-cycle valid for VAR_SCALED/ALARM.
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [15:0] op_q, op_d;
  logic [27:0] sq_q, sq_d;
  logic [31:0] th_q, th_d;
  logic [31:0] var_q, var_d;
  logic        done_q, done_d;
  logic        alarm_q, alarm_d;
  logic        overrun_q, overrun_d;

  logic        capture;
  logic [31:0] addend;
  logic [31:0] sq_ext;
  logic [31:0] n_sq;
  logic [32:0] diff;
  logic [31:0] d_val;

  assign capture = START && (state_q == S_IDLE) && !done_q;
  assign sq_ext  = {4'b0, sq_q};
  // N=14 uses the shift form (16x - 2x); other windows fall back to a constant multiply.
  assign n_sq    = (WINDOW == 14) ? ((sq_ext << 4) - (sq_ext << 1)) : (sq_ext * N_SCALE);
  assign diff    = {1'b0, n_sq} - {1'b0, acc_q};
  assign d_val   = diff[32] ? 32'd0 : diff[31:0];
  assign addend  = op_q[cnt_q] ? ({16'b0, op_q} << cnt_q) : 32'd0;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    op_d      = op_q;
    sq_d      = sq_q;
    th_d      = th_q;
    var_d     = var_q;
    done_d    = 1'b0;
    alarm_d   = alarm_q;
    overrun_d = overrun_q | (START && ((state_q != S_IDLE) || done_q));
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          op_d    = Tsum;
          sq_d    = Tsum_square;
          th_d    = THRESH;
          acc_d   = 32'd0;
          cnt_d   = 4'd0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        acc_d = acc_q + addend;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = S_SUB;
      end
      S_SUB: begin
        var_d  = d_val;
`ifdef VARIANCE_HYST_EN
        if (d_val > th_q)             alarm_d = 1'b1;
        else if (d_val <= (th_q >> 1)) alarm_d = 1'b0;
`else
        alarm_d = (d_val > th_q);
`endif
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      acc_q     <= 32'd0;
      op_q      <= 16'd0;
      sq_q      <= 28'd0;
      th_q      <= 32'd0;
      var_q     <= 32'd0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      op_q      <= op_d;
      sq_q      <= sq_d;
      th_q      <= th_d;
      var_q     <= var_d;
      done_q    <= done_d;
      alarm_q   <= alarm_d;
      overrun_q <= overrun_d;
    end
  end

  assign BUSY       = (state_q != S_IDLE);
  assign DONE       = done_q;
  assign VAR_SCALED = var_q;
  assign ALARM      = alarm_q;
  assign OVERRUN    = overrun_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_variance_detector.sv
// Directed bench for variance_detector: a vector table of operands/expected results plus
// hand-written overrun, DONE-cycle START and mid-computation reset sequences.
module tb_variance_detector;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic [15:0] Tsum = '0;
  logic [27:0] Tsum_square = '0;
  logic [31:0] THRESH = '0;
  logic        BUSY, DONE, ALARM, OVERRUN;
  logic [31:0] VAR_SCALED;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;

  variance_detector #(.WINDOW(14)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .Tsum(Tsum), .Tsum_square(Tsum_square),
    .THRESH(THRESH), .BUSY(BUSY), .DONE(DONE), .VAR_SCALED(VAR_SCALED), .ALARM(ALARM),
    .OVERRUN(OVERRUN), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] tsum;
    logic [27:0] tsq;
    logic [31:0] thresh;
    logic [31:0] exp_var;
    logic        exp_alarm;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drives one capture and waits for DONE; checks latency, BUSY profile, result and pulse width.
  task automatic run_op(input logic [15:0] ts, input logic [27:0] tq, input logic [31:0] th,
                        input logic [31:0] exp_var, input logic exp_alarm);
    int n;
    logic busy_ok;
    Tsum = ts; Tsum_square = tq; THRESH = th; START = 1'b1;
    tick();
    START = 1'b0;
    Tsum = '0; Tsum_square = '0; THRESH = '0;
    n = 0;
    busy_ok = 1'b1;
    while (!DONE && n < 40) begin
      if (!BUSY) busy_ok = 1'b0;
      tick();
      n++;
    end
    check("latency", 64'(n), 64'd17);
    check("busy_before_done", 64'(busy_ok), 64'd1);
    check("busy_at_done", 64'(BUSY), 64'd0);
    check("var_scaled", 64'(VAR_SCALED), 64'(exp_var));
    check("alarm", 64'(ALARM), 64'(exp_alarm));
    tick();
    check("done_single_cycle", 64'(DONE), 64'd0);
    check("result_held", 64'(VAR_SCALED), 64'(exp_var));
  endtask

  initial begin
    int dones;
    logic [31:0] seen_var;

    vecs[0] = '{16'd70,    28'd350,       32'd0,    32'd0,          1'b0};
    vecs[1] = '{16'd105,   28'd1015,      32'd3000, 32'd3185,       1'b1};
`ifdef VARIANCE_HYST_EN
    vecs[2] = '{16'd105,   28'd1015,      32'd3185, 32'd3185,       1'b1};
`else
    vecs[2] = '{16'd105,   28'd1015,      32'd3185, 32'd3185,       1'b0};
`endif
    vecs[3] = '{16'd57330, 28'd234766350, 32'd0,    32'd0,          1'b0};
    vecs[4] = '{16'd0,     28'd234766350, 32'd100,  32'd3286728900, 1'b1};
    vecs[5] = '{16'd100,   28'd0,         32'd0,    32'd0,          1'b0};
    vecs[6] = '{16'd3,     28'd5,         32'd0,    32'd61,         1'b1};
    vecs[7] = '{16'd10,    28'd20,        32'd61,   32'd180,        1'b1};

    #12;
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_done", 64'(DONE), 64'd0);
    check("rst_var", 64'(VAR_SCALED), 64'd0);
    check("rst_alarm", 64'(ALARM), 64'd0);
    check("rst_overrun", 64'(OVERRUN), 64'd0);
    RESET = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].tsum, vecs[i].tsq, vecs[i].thresh, vecs[i].exp_var, vecs[i].exp_alarm);
    end
    check("no_overrun_clean", 64'(OVERRUN), 64'd0);

    // START inside the DONE cycle is dropped and flags OVERRUN
    Tsum = 16'd105; Tsum_square = 28'd1015; THRESH = 32'd0; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 40 && !DONE; k++) tick();
    check("done_seen", 64'(DONE), 64'd1);
    START = 1'b1; Tsum = 16'd70; Tsum_square = 28'd350;
    tick();
    START = 1'b0;
    check("done_cycle_start_no_capture", 64'(BUSY), 64'd0);
    check("done_cycle_start_overrun", 64'(OVERRUN), 64'd1);

    // Reset clears OVERRUN; then a second START 5 cycles into a computation
    RESET = 1'b0;
    #2;
    check("overrun_cleared", 64'(OVERRUN), 64'd0);
    RESET = 1'b1;
    tick();
    Tsum = 16'd105; Tsum_square = 28'd1015; THRESH = 32'd0; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    Tsum = 16'd70; Tsum_square = 28'd350; START = 1'b1;
    tick();
    START = 1'b0;
    check("overrun_set", 64'(OVERRUN), 64'd1);
    dones = 0;
    seen_var = '0;
    for (int k = 0; k < 40; k++) begin
      if (DONE) begin
        dones++;
        seen_var = VAR_SCALED;
      end
      tick();
    end
    check("overrun_done_count", 64'(dones), 64'd1);
    check("overrun_first_operands", 64'(seen_var), 64'd3185);
    check("overrun_sticky", 64'(OVERRUN), 64'd1);

    // Reset during MUL cycle 8 aborts with no DONE; next START computes normally
    Tsum = 16'd3; Tsum_square = 28'd5; THRESH = 32'd0; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check("mid_mul_busy", 64'(BUSY), 64'd1);
    RESET = 1'b0;
    #1;
    check("mid_rst_busy", 64'(BUSY), 64'd0);
    check("mid_rst_var", 64'(VAR_SCALED), 64'd0);
    check("mid_rst_alarm", 64'(ALARM), 64'd0);
    check("mid_rst_overrun", 64'(OVERRUN), 64'd0);
    check("mid_rst_done", 64'(DONE), 64'd0);
    tick();
    tick();
    RESET = 1'b1;
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      if (DONE) dones++;
      tick();
    end
    check("aborted_no_done", 64'(dones), 64'd0);
    run_op(16'd105, 28'd1015, 32'd3000, 32'd3185, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

endmodule
